// File: rtl/console_tx_pkg.sv
// Shared parameters for the console output path: dekatron cell geometry,
// default UART/buffer sizing, transmitter state encoding and the
// one-hot-decimal to byte conversion used when a '.' instruction fires.
package console_tx_pkg;

   localparam int DEKATRON_WIDTH     = 10;
   localparam int DATA_DEKATRON_NUM  = 3;
   localparam int DATA_WIDTH         = DEKATRON_WIDTH * DATA_DEKATRON_NUM;
   localparam int BAUD_DIV_DEFAULT   = 16;
   localparam int FIFO_DEPTH_DEFAULT = 4;

   typedef logic [1:0] tx_state_t;
   localparam tx_state_t TX_IDLE  = 2'd0;
   localparam tx_state_t TX_START = 2'd1;
   localparam tx_state_t TX_DATA  = 2'd2;
   localparam tx_state_t TX_STOP  = 2'd3;

   typedef struct packed {
      logic [7:0] value;   // cell value mod 256
      logic       bad;     // some slice was not exactly one-hot
   } conv_t;

   // Each slice is one decimal digit, units in the LSB slice. A slice that is
   // not one-hot contributes 0 and flags the result. Accumulating mod 2^16
   // keeps the low byte exact, so the weight overflowing on the last digit
   // of a wider cell is harmless.
   function automatic conv_t convert(input logic [DATA_WIDTH-1:0] data);
      conv_t                     r;
      logic [15:0]               acc;
      logic [15:0]               weight;
      logic [3:0]                digit;
      logic [DEKATRON_WIDTH-1:0] slice;
      r      = '0;
      acc    = '0;
      weight = 16'd1;
      for (int k = 0; k < DATA_DEKATRON_NUM; k++) begin
         slice = data[k*DEKATRON_WIDTH +: DEKATRON_WIDTH];
         digit = 4'd0;
         if ($onehot(slice)) begin
            for (int i = 0; i < DEKATRON_WIDTH; i++) begin
               if (slice[i]) digit = 4'(i);
            end
         end else begin
            r.bad = 1'b1;
         end
         acc    = acc + weight * {12'd0, digit};
         weight = weight * 16'd10;
      end
      r.value = acc[7:0];
      return r;
   endfunction

endpackage

// File: rtl/console_tx_core.sv
// Serial side of console_tx: 8N1 shift register, baud counter and framing FSM.
// Ports: Clk/Rst_n; avail/head = buffer non-empty and its oldest byte;
//        take = head consumed this edge; active = frame in flight; tx = line.
module uart_tx_core
   import console_tx_pkg::*;
#(
   parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
   input  logic       Clk,
   input  logic       Rst_n,
   input  logic       avail,
   input  logic [7:0] head,
   output logic       take,
   output logic       active,
   output logic       tx
);

   localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

   tx_state_t   state;
   logic [7:0]  shreg;
   logic [2:0]  bit_cnt;
   logic [15:0] baud_cnt;
   logic        bit_end;

   assign bit_end = (baud_cnt == BAUD_LAST);
   // Loading happens straight out of IDLE, so IDLE lasts a single cycle
   // between consecutive frames.
   assign take    = (state == TX_IDLE) && avail;
   assign active  = (state != TX_IDLE);

   // tx is a flop, so the line never sees decode glitches.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state    <= TX_IDLE;
         shreg    <= '0;
         bit_cnt  <= '0;
         baud_cnt <= '0;
         tx       <= 1'b1;
      end else begin
         case (state)
            TX_IDLE: begin
               tx <= 1'b1;
               if (take) begin
                  shreg    <= head;
                  bit_cnt  <= '0;
                  baud_cnt <= '0;
                  tx       <= 1'b0;
                  state    <= TX_START;
               end
            end
            TX_START: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  tx       <= shreg[0];
                  state    <= TX_DATA;
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            TX_DATA: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (bit_cnt == 3'd7) begin
                     tx    <= 1'b1;
                     state <= TX_STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                     shreg   <= {1'b0, shreg[7:1]};
                     tx      <= shreg[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            TX_STOP: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  state    <= TX_IDLE;
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            default: state <= TX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/console_tx.sv
// Console output: converts the dekatron cell to a byte on each Cout strobe,
// buffers it and sends it as UART 8N1 via uart_tx_core.
// Ports: Clk/Rst_n; Cout strobe + Data cell; Tx line; Full/Busy status;
//        sticky Overflow (strobe dropped) and BadDigit (non-one-hot slice).
module console_tx
   import console_tx_pkg::*;
#(
   parameter int BAUD_DIV   = BAUD_DIV_DEFAULT,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
   input  logic                  Clk,
   input  logic                  Rst_n,
   input  logic                  Cout,
   input  logic [DATA_WIDTH-1:0] Data,
   output logic                  Tx,
   output logic                  Full,
   output logic                  Busy,
   output logic                  Overflow,
   output logic                  BadDigit
);

   localparam int         PW      = $clog2(FIFO_DEPTH);
   localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;
   conv_t         conv;
   logic          push;
   logic          pop;
   logic          active;

   assign conv = convert(Data);
   // Full is judged on the registered count: a pop on the same edge does not
   // make room for the strobe.
   assign push = Cout && (count != DEPTH_C);
   assign Full = (count == DEPTH_C);
   assign Busy = (count != '0) || active;

   always_ff @(posedge Clk) begin
      if (push) mem[wr_ptr] <= conv.value;
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         Overflow <= 1'b0;
         BadDigit <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
         if (Cout && !push) Overflow <= 1'b1;
         if (Cout && conv.bad) BadDigit <= 1'b1;
      end
   end

   uart_tx_core #(
      .BAUD_DIV (BAUD_DIV)
   ) u_core (
      .Clk    (Clk),
      .Rst_n  (Rst_n),
      .avail  (count != '0),
      .head   (mem[rd_ptr]),
      .take   (pop),
      .active (active),
      .tx     (Tx)
   );

endmodule

// File: tb/tb_console_tx.sv
// Bench for console_tx: random and directed cells, expected bytes computed
// from decimal arithmetic, Tx decoded as a UART receiver at the bit level.
// Checks frame timing, status flags, overflow and reset behaviour.
module tb_console_tx;
   import console_tx_pkg::*;

   localparam int BAUD  = 4;
   localparam int DEPTH = 4;
   localparam int FRAME = 10 * BAUD;

   logic                  Clk;
   logic                  Rst_n;
   logic                  Cout;
   logic [DATA_WIDTH-1:0] Data;
   logic                  Tx;
   logic                  Full;
   logic                  Busy;
   logic                  Overflow;
   logic                  BadDigit;

   int tests  = 0;
   int failed = 0;
   int cyc    = 0;

   console_tx #(.BAUD_DIV(BAUD), .FIFO_DEPTH(DEPTH)) dut (
      .Clk      (Clk),
      .Rst_n    (Rst_n),
      .Cout     (Cout),
      .Data     (Data),
      .Tx       (Tx),
      .Full     (Full),
      .Busy     (Busy),
      .Overflow (Overflow),
      .BadDigit (BadDigit)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [DATA_WIDTH-1:0] enc(input int h, input int t, input int u);
      logic [DATA_WIDTH-1:0] d;
      d = '0;
      d[u] = 1'b1;
      d[DEKATRON_WIDTH + t] = 1'b1;
      d[2*DEKATRON_WIDTH + h] = 1'b1;
      return d;
   endfunction

   function automatic logic [7:0] ref_byte(input int h, input int t, input int u);
      return 8'((h * 100 + t * 10 + u) % 256);
   endfunction

   task automatic do_reset();
      Rst_n = 1'b0;
      Cout  = 1'b0;
      repeat (2) @(negedge Clk);
      Rst_n = 1'b1;
   endtask

   // Strobe for one edge; k = that edge's index.
   task automatic send(input logic [DATA_WIDTH-1:0] d, output int k);
      @(negedge Clk);
      Data = d;
      Cout = 1'b1;
      @(negedge Clk);
      k    = cyc;
      Cout = 1'b0;
      Data = DATA_WIDTH'($urandom);
   endtask

   // Wait for a start bit, then sample a whole 10-bit frame once per cycle.
   task automatic get_frame(input int max_wait, output logic [7:0] b, output int start,
                            output bit found, output bit shape_ok);
      int n;
      int slot;
      n = 0; b = '0; start = -1; found = 0; shape_ok = 1;
      @(negedge Clk);
      while (Tx !== 1'b0 && n < max_wait) begin
         @(negedge Clk);
         n++;
      end
      if (Tx !== 1'b0) return;
      found = 1;
      start = cyc;
      for (int s = 0; s < FRAME; s++) begin
         if (s > 0) @(negedge Clk);
         slot = s / BAUD;
         if (slot == 0) begin
            if (Tx !== 1'b0) shape_ok = 0;
         end else if (slot == 9) begin
            if (Tx !== 1'b1) shape_ok = 0;
         end else if (s % BAUD == 0) begin
            b[slot-1] = Tx;
         end else if (Tx !== b[slot-1]) begin
            shape_ok = 0;
         end
      end
   endtask

   task automatic expect_frame(input string tag, input logic [7:0] exp_b, input int k);
      logic [7:0] b;
      int         st;
      bit         fnd;
      bit         ok;
      get_frame(2000, b, st, fnd, ok);
      check({tag, "_found"}, fnd, 1);
      if (fnd) begin
         check({tag, "_byte"}, b, exp_b);
         check({tag, "_shape"}, ok, 1);
         check({tag, "_start"}, st, k + 1);
      end
   endtask

   initial begin
      int         k;
      int         k2;
      int         h, t, u;
      int         hv[6], tv[6], uv[6];
      logic [7:0] rb[6];
      int         rs[6];
      bit         rf[6];
      bit         rok[6];
      logic [DATA_WIDTH-1:0] d;
      int         lows;

      Rst_n = 1'b0;
      Cout  = 1'b0;
      Data  = '0;
      repeat (3) @(negedge Clk);
      check("rst_tx", Tx, 1);
      check("rst_full", Full, 0);
      check("rst_busy", Busy, 0);
      check("rst_ovf", Overflow, 0);
      check("rst_bad", BadDigit, 0);
      Rst_n = 1'b1;
      @(negedge Clk);

      // 065 -> 0x41, latency and Busy duration
      send(enc(0, 6, 5), k);
      check("t1_tx_pre", Tx, 1);
      check("t1_busy_pre", Busy, 1);
      expect_frame("t1", 8'h41, k);
      check("t1_busy_last", Busy, 1);
      @(negedge Clk);
      check("t1_busy_drop", Busy, 0);
      check("t1_tx_idle", Tx, 1);

      // 999 -> 0xE7
      send(enc(9, 9, 9), k);
      expect_frame("t2", 8'hE7, k);
      check("t2_bad", BadDigit, 0);

      // random cells, random gaps
      for (int i = 0; i < 8; i++) begin
         repeat ($urandom_range(0, 5)) @(negedge Clk);
         h = $urandom_range(0, 9);
         t = $urandom_range(0, 9);
         u = $urandom_range(0, 9);
         send(enc(h, t, u), k);
         expect_frame($sformatf("rnd%0d", i), ref_byte(h, t, u), k);
      end
      check("rnd_bad", BadDigit, 0);
      check("rnd_ovf", Overflow, 0);

      // six consecutive strobes: one sent at once, four buffered, one dropped
      for (int i = 0; i < 6; i++) begin
         hv[i] = $urandom_range(0, 9);
         tv[i] = $urandom_range(0, 9);
         uv[i] = $urandom_range(0, 9);
      end
      fork
         begin
            @(negedge Clk);
            for (int i = 0; i < 6; i++) begin
               Data = enc(hv[i], tv[i], uv[i]);
               Cout = 1'b1;
               @(negedge Clk);
               if (i == 0) k = cyc;
            end
            Cout = 1'b0;
            check("t4_full", Full, 1);
            check("t4_ovf", Overflow, 1);
         end
         begin
            for (int j = 0; j < 6; j++)
               get_frame(j < 5 ? 2000 : 3 * BAUD, rb[j], rs[j], rf[j], rok[j]);
         end
      join
      for (int j = 0; j < 5; j++) begin
         check($sformatf("t4_found%0d", j), rf[j], 1);
         check($sformatf("t4_byte%0d", j), rb[j], ref_byte(hv[j], tv[j], uv[j]));
         check($sformatf("t4_shape%0d", j), rok[j], 1);
         check($sformatf("t4_start%0d", j), rs[j], k + 1 + j * (FRAME + 1));
      end
      check("t4_no_sixth", rf[5], 0);
      check("t4_busy_end", Busy, 0);

      // BadDigit: empty units slice, then a doubly-lit hundreds slice
      d = enc(0, 1, 0);
      d[DEKATRON_WIDTH-1:0] = '0;
      send(d, k);
      expect_frame("t3a", 8'h0A, k);
      check("t3a_bad", BadDigit, 1);
      d = enc(2, 3, 4);
      d[2*DEKATRON_WIDTH + 7] = 1'b1;
      send(d, k);
      expect_frame("t3b", 8'h22, k);
      send(enc(1, 2, 3), k);
      expect_frame("t3c", ref_byte(1, 2, 3), k);
      check("t3_bad_sticky", BadDigit, 1);
      do_reset();
      check("t3_bad_clr", BadDigit, 0);
      check("t3_ovf_clr", Overflow, 0);

      // strobe on the very edge that pops from a full buffer is dropped
      for (int i = 0; i < 6; i++) begin
         hv[i] = $urandom_range(0, 9);
         tv[i] = $urandom_range(0, 9);
         uv[i] = $urandom_range(0, 9);
      end
      fork
         begin
            send(enc(hv[0], tv[0], uv[0]), k);
            @(negedge Clk);
            for (int i = 1; i < 5; i++) begin
               Data = enc(hv[i], tv[i], uv[i]);
               Cout = 1'b1;
               @(negedge Clk);
            end
            Cout = 1'b0;
            check("t5_full", Full, 1);
            check("t5_ovf_pre", Overflow, 0);
            // first frame ends k+1+FRAME, IDLE one cycle, pop at k+2+FRAME
            while (cyc < k + 1 + FRAME) @(negedge Clk);
            Data = enc(hv[5], tv[5], uv[5]);
            Cout = 1'b1;
            @(negedge Clk);
            Cout = 1'b0;
            check("t5_ovf", Overflow, 1);
            check("t5_full_after", Full, 0);
            check("t5_busy", Busy, 1);
         end
         begin
            for (int j = 0; j < 6; j++)
               get_frame(j < 5 ? 2000 : 3 * BAUD, rb[j], rs[j], rf[j], rok[j]);
         end
      join
      for (int j = 0; j < 5; j++) begin
         check($sformatf("t5_found%0d", j), rf[j], 1);
         check($sformatf("t5_byte%0d", j), rb[j], ref_byte(hv[j], tv[j], uv[j]));
         check($sformatf("t5_start%0d", j), rs[j], k + 1 + j * (FRAME + 1));
      end
      check("t5_no_sixth", rf[5], 0);

      // reset during data bit 3 of 0x41 with bytes still buffered
      do_reset();
      send(enc(0, 6, 5), k);
      send(enc(1, 1, 1), k2);
      send(enc(2, 2, 2), k2);
      while (cyc < k + 2 + BAUD + 3 * BAUD) @(negedge Clk);
      check("t6_tx_bit3", Tx, 0);
      check("t6_busy_pre", Busy, 1);
      Rst_n = 1'b0;
      #1;
      check("t6_tx_async", Tx, 1);
      check("t6_busy_async", Busy, 0);
      check("t6_full_async", Full, 0);
      repeat (2) @(negedge Clk);
      Rst_n = 1'b1;
      lows = 0;
      repeat (15 * BAUD) begin
         @(negedge Clk);
         if (Tx !== 1'b1) lows++;
      end
      check("t6_no_frame", lows, 0);
      check("t6_busy_post", Busy, 0);

      // a strobe held through reset is honoured on the first edge after it
      @(negedge Clk);
      Rst_n = 1'b0;
      Data  = enc(1, 2, 3);
      Cout  = 1'b1;
      @(negedge Clk);
      Rst_n = 1'b1;
      @(negedge Clk);
      k    = cyc;
      Cout = 1'b0;
      expect_frame("t7", ref_byte(1, 2, 3), k);
      get_frame(3 * BAUD, rb[0], rs[0], rf[0], rok[0]);
      check("t7_single", rf[0], 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
